seq_divider_param: RTL and testbench

//  Parametrised multi-cycle restoring divider, datapath plus FSM in one block.

---
 rtl/seq_divider_param_pkg.sv | 36 +++
 rtl/seq_divider_param_if.sv | 36 +++
 rtl/seq_divider_param_step.sv | 31 +++
 rtl/seq_divider_param.sv | 213 +++++++++++++++++++++
 tb/tb_seq_divider_param.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_param_pkg.sv
// ----------------------------------------------------------------------------
// seq_div_pkg
// Shared definitions for the sequential restoring divider:
//   - state_e     : controller states (IDLE / CALC / DONE)
//   - STATE_W     : width of the state encoding
//   - all_ones()  : all-ones pattern of a given width (unsigned saturation)
//   - sat_max_pos(): largest positive two's complement value of a given width
//   - sat_min_neg(): most negative two's complement value of a given width
// The helpers return 64-bit values so callers can size them with a cast.
// ----------------------------------------------------------------------------
package seq_div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [63:0] all_ones(input int unsigned w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_max_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage : seq_div_pkg

// File: rtl/seq_divider_param_if.sv
// ----------------------------------------------------------------------------
// seq_divider_param_if
// Start/valid handshake and result bus of the sequential divider.
//   start      : request, sampled only while the divider is idle
//   a, b       : dividend / divisor (W bits)
//   busy       : divider iterating
//   valid      : one-cycle result strobe
//   dvz, ovf   : divide-by-zero / quotient overflow flags
//   q, r       : quotient / remainder (W bits)
// Modports: master = requester (drives start/a/b), slave = divider.
// ----------------------------------------------------------------------------
interface seq_divider_param_if #(
  parameter int W = 8
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         valid;
  logic         dvz;
  logic         ovf;
  logic [W-1:0] q;
  logic [W-1:0] r;

  modport master (
    output start, a, b,
    input  busy, valid, dvz, ovf, q, r
  );

  modport slave (
    input  start, a, b,
    output busy, valid, dvz, ovf, q, r
  );

endinterface : seq_divider_param_if

// File: rtl/seq_divider_param_step.sv
// ----------------------------------------------------------------------------
// seq_div_step
// One combinational restoring-division step.
//   p_i     : current partial remainder (W bits, always < b_i)
//   d_msb_i : dividend bit shifted into the remainder this step
//   b_i     : divisor (W bits, non-zero)
//   p_o     : next partial remainder
//   qbit_o  : quotient bit produced by this step
// The shifted remainder needs W+1 bits; because the incoming remainder is
// below the divisor, the restored result always fits back into W bits, so the
// subtraction can be done modulo 2^W once the full-width compare has decided.
// ----------------------------------------------------------------------------
module seq_div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] p_i,
  input  logic         d_msb_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] p_o,
  output logic         qbit_o
);

  logic [W:0]   shifted;
  logic [W-1:0] sub_lo;

  assign shifted = {p_i, d_msb_i};
  assign sub_lo  = shifted[W-1:0] - b_i;
  assign qbit_o  = (shifted >= {1'b0, b_i});
  assign p_o     = qbit_o ? sub_lo : shifted[W-1:0];

endmodule : seq_div_step

// File: rtl/seq_divider_param.sv
// ----------------------------------------------------------------------------
// seq_divider_param
// Multi-cycle restoring divider producing the fixed-point quotient
// Q = (A << F) / B and remainder R, one quotient bit per clock.
//   clk   : rising-edge clock
//   sclr  : synchronous active-high clear, overrides everything
//   bus   : seq_divider_param_if.slave (start/a/b in; busy/valid/dvz/ovf/q/r out)
// Timing: start accepted at edge E0 -> busy for N=W+F cycles -> valid for one
// cycle. b==0 skips straight to the result cycle with dvz set. A 1 in any
// quotient bit of weight >= W aborts early with ovf and a saturated q.
// Optional build macro SEQDIV_SIGNED_EN: operands are two's complement; the
// core divides magnitudes and the signs are applied when entering DONE
// (q sign = sign(a)^sign(b), r sign = sign(a), ovf saturates to the signed
// extreme). Without the macro the divider is unsigned only.
// ----------------------------------------------------------------------------
module seq_divider_param
  import seq_div_pkg::*;
#(
  parameter int W = 8,
  parameter int F = 4
) (
  input logic                clk,
  input logic                sclr,
  seq_divider_param_if.slave bus
);

  localparam int N  = W + F;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] F_CNT    = CW'(F);
  localparam logic [W-1:0]  Q_ONES   = W'(all_ones(W));
`ifdef SEQDIV_SIGNED_EN
  localparam logic [W-1:0]  Q_MAX_POS = W'(sat_max_pos(W));
  localparam logic [W-1:0]  Q_MIN_NEG = W'(sat_min_neg(W));
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  d_q,     d_d;
  logic [W-1:0]  p_q,     p_d;
  logic [W-1:0]  b_q,     b_d;
  logic [W-1:0]  q_q,     q_d;
  logic [W-1:0]  r_q,     r_d;
  logic          dvz_q,   dvz_d;
  logic          ovf_q,   ovf_d;
`ifdef SEQDIV_SIGNED_EN
  logic          qneg_q,  qneg_d;
  logic          rneg_q,  rneg_d;
`endif

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W-1:0]  step_p;
  logic          step_qbit;
  logic [N-1:0]  d_shift;
  logic          int_phase;

  // Magnitudes fed to the unsigned core. For a = -2^(W-1) the negation wraps
  // to 2^(W-1), which is the correct magnitude when read as unsigned W bits.
`ifdef SEQDIV_SIGNED_EN
  assign a_mag = bus.a[W-1] ? (-bus.a) : bus.a;
  assign b_mag = bus.b[W-1] ? (-bus.b) : bus.b;
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif

  seq_div_step #(
    .W (W)
  ) u_step (
    .p_i     (p_q),
    .d_msb_i (d_q[N-1]),
    .b_i     (b_q),
    .p_o     (step_p),
    .qbit_o  (step_qbit)
  );

  // Dividend shifts left, quotient bits enter at the LSB.
  assign d_shift   = {d_q[N-2:0], step_qbit};
  // The first F iterations produce quotient bits of weight >= W.
  assign int_phase = (cnt_q < F_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    p_d     = p_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dvz_d   = dvz_q;
    ovf_d   = ovf_q;
`ifdef SEQDIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dvz_d = 1'b0;
          ovf_d = 1'b0;
          if (bus.b == '0) begin
            state_d = ST_DONE;
            dvz_d   = 1'b1;
            q_d     = Q_ONES;
            r_d     = '0;
          end else begin
            state_d = ST_CALC;
            cnt_d   = '0;
            d_d     = N'(a_mag) << F;
            p_d     = '0;
            b_d     = b_mag;
`ifdef SEQDIV_SIGNED_EN
            qneg_d  = bus.a[W-1] ^ bus.b[W-1];
            rneg_d  = bus.a[W-1];
`endif
          end
        end
      end

      ST_CALC: begin
        cnt_d = cnt_q + CW'(1);
        d_d   = d_shift;
        p_d   = step_p;
        if (int_phase && step_qbit) begin
          state_d = ST_DONE;
          ovf_d   = 1'b1;
          r_d     = '0;
`ifdef SEQDIV_SIGNED_EN
          q_d     = qneg_q ? Q_MIN_NEG : Q_MAX_POS;
`else
          q_d     = Q_ONES;
`endif
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
`ifdef SEQDIV_SIGNED_EN
          // Magnitude may still exceed the signed range of the result.
          if (qneg_q) begin
            if (d_shift[W-1:0] > Q_MIN_NEG) begin
              ovf_d = 1'b1;
              q_d   = Q_MIN_NEG;
            end else begin
              q_d   = -d_shift[W-1:0];
            end
          end else begin
            if (d_shift[W-1:0] > Q_MAX_POS) begin
              ovf_d = 1'b1;
              q_d   = Q_MAX_POS;
            end else begin
              q_d   = d_shift[W-1:0];
            end
          end
          r_d = rneg_q ? (-step_p) : step_p;
`else
          q_d = d_shift[W-1:0];
          r_d = step_p;
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      p_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SEQDIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      p_q     <= p_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvz_q   <= dvz_d;
      ovf_q   <= ovf_d;
`ifdef SEQDIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  // All outputs come straight from registers.
  assign bus.busy  = (state_q == ST_CALC);
  assign bus.valid = (state_q == ST_DONE);
  assign bus.dvz   = dvz_q;
  assign bus.ovf   = ovf_q;
  assign bus.q     = q_q;
  assign bus.r     = r_q;

endmodule : seq_divider_param

// File: tb/tb_seq_divider_param.sv
// ----------------------------------------------------------------------------
// tb_seq_divider_param
// Self-checking bench for seq_divider_param (W=8, F=4). Expected results and
// latencies come from an integer-arithmetic reference model of (A<<F)/B.
// Honours SEQDIV_SIGNED_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_seq_divider_param;

  localparam int W = 8;
  localparam int F = 4;
  localparam int N = W + F;

  logic clk = 1'b0;
  logic sclr;

  always #5 clk = ~clk;

  seq_divider_param_if #(.W(W)) bus ();

  seq_divider_param #(
    .W (W),
    .F (F)
  ) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dvz;
    logic         ovf;
    int           lat;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s (txn %0d): observed=%0h expected=%0h", tag, txn_no, got, exp);
    end
  endtask

  // Reference: plain integer division of the scaled dividend.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint na, nb, mag_a, mag_b, qm, rm, hi, half;
    bit     neg_q, neg_a;
    int     msb;
    e.q   = '1;
    e.r   = '0;
    e.dvz = 1'b0;
    e.ovf = 1'b0;
    e.lat = N + 1;
    if (b == '0) begin
      e.dvz = 1'b1;
      e.lat = 1;
      return e;
    end
`ifdef SEQDIV_SIGNED_EN
    na = longint'($signed(a));
    nb = longint'($signed(b));
`else
    na = longint'(a);
    nb = longint'(b);
`endif
    neg_a = (na < 0);
    neg_q = (na < 0) != (nb < 0);
    mag_a = neg_a ? -na : na;
    mag_b = (nb < 0) ? -nb : nb;
    qm    = (mag_a << F) / mag_b;
    rm    = (mag_a << F) % mag_b;
    half  = longint'(1) << (W - 1);
    hi    = qm >> W;
    if (hi != 0) begin
      // The highest set bit of weight W+j emerges in iteration F-1-j.
      msb = 0;
      for (int j = 0; j < F; j++) begin
        if (hi[j]) msb = j;
      end
      e.ovf = 1'b1;
      e.lat = (F - 1 - msb) + 2;
`ifdef SEQDIV_SIGNED_EN
      e.q = neg_q ? W'(half) : W'(half - 1);
`else
      e.q = neg_q ? '0 : '1;
`endif
      return e;
    end
`ifdef SEQDIV_SIGNED_EN
    if (neg_q && qm > half) begin
      e.ovf = 1'b1;
      e.q   = W'(half);
    end else if (!neg_q && qm > half - 1) begin
      e.ovf = 1'b1;
      e.q   = W'(half - 1);
    end else begin
      e.q = W'(neg_q ? -qm : qm);
    end
`else
    e.q = W'(qm);
`endif
    e.r = W'(neg_a ? -rm : rm);
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"},  32'(bus.busy),  32'd0);
    chk({tag, ".valid"}, 32'(bus.valid), 32'd0);
    chk({tag, ".dvz"},   32'(bus.dvz),   32'd0);
    chk({tag, ".ovf"},   32'(bus.ovf),   32'd0);
    chk({tag, ".q"},     32'(bus.q),     32'd0);
    chk({tag, ".r"},     32'(bus.r),     32'd0);
  endtask

  // Issue one request and follow it cycle by cycle up to the idle cycle after
  // valid. With poke set, a second start is raised mid-calculation.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    exp_t e;
    e = model(a, b);
    txn_no++;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= e.lat; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      bus.start = 1'b0;
      chk("busy",  32'(bus.busy),  32'(cyc < e.lat));
      chk("valid", 32'(bus.valid), 32'(cyc == e.lat));
      if (poke && cyc == 6 && e.lat > 7) begin
        bus.start = 1'b1;
        bus.a     = ~a;
        bus.b     = b ^ 8'h3C;
      end
    end
    chk("q",   32'(bus.q),   32'(e.q));
    chk("dvz", 32'(bus.dvz), 32'(e.dvz));
    chk("ovf", 32'(bus.ovf), 32'(e.ovf));
    if (!e.ovf) chk("r", 32'(bus.r), 32'(e.r));
    $display("txn %0d: a=%0h b=%0h -> q=%0h r=%0h dvz=%0b ovf=%0b lat=%0d",
             txn_no, a, b, bus.q, bus.r, bus.dvz, bus.ovf, e.lat);
    @(posedge clk);
    #1;
    chk("valid_after", 32'(bus.valid), 32'd0);
    chk("busy_after",  32'(bus.busy),  32'd0);
    chk("q_hold",      32'(bus.q),     32'(e.q));
    chk("dvz_hold",    32'(bus.dvz),   32'(e.dvz));
    chk("ovf_hold",    32'(bus.ovf),   32'(e.ovf));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int unsigned  mode;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    sclr      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sclr = 1'b0;
    check_all_zero("reset");

    // Directed cases.
    run_txn(8'd6,   8'd3,   1'b0);
    run_txn(8'd200, 8'd3,   1'b0);
    run_txn(8'd17,  8'd0,   1'b0);
    run_txn(8'd7,   8'd200, 1'b1);
    run_txn(8'd255, 8'd255, 1'b0);
    run_txn(8'd15,  8'd1,   1'b0);
    run_txn(8'd16,  8'd1,   1'b0);

    // Synchronous clear in the middle of a calculation.
    txn_no++;
    bus.a     = 8'd6;
    bus.b     = 8'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_pre_sclr", 32'(bus.busy), 32'd1);
    sclr = 1'b1;
    @(posedge clk);
    #1;
    sclr = 1'b0;
    check_all_zero("sclr");
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      #1;
      chk("valid_post_sclr", 32'(bus.valid), 32'd0);
      chk("busy_post_sclr",  32'(bus.busy),  32'd0);
    end
    $display("txn %0d: sclr during calculation", txn_no);
    run_txn(8'd6, 8'd3, 1'b0);

`ifdef SEQDIV_SIGNED_EN
    run_txn(8'hFA, 8'd3, 1'b0);
    chk("signed_q_neg", 32'(bus.q), 32'h0000_00E0);
    run_txn(8'h80, 8'd1, 1'b0);
    chk("signed_ovf",   32'(bus.ovf), 32'd1);
    chk("signed_q_min", 32'(bus.q),   32'h0000_0080);
    run_txn(8'hF9, 8'hFE, 1'b0);
`endif

    // Randomised operands.
    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 7);
      ra   = W'($urandom_range(0, 255));
      if (mode == 0)      rb = '0;
      else if (mode < 4)  rb = W'($urandom_range(128, 255));
      else                rb = W'($urandom_range(1, 255));
      if (mode == 7)      ra = W'($urandom_range(0, 15));
      run_txn(ra, rb, (mode == 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_divider_param
